// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Desc     : Shared types for the configurable UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // data_xor is the reduction XOR of the payload; odd parity inverts it.
  function automatic logic parity_bit(input parity_e mode, input logic data_xor);
    return data_xor ^ (mode == PAR_ODD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_cnt
// Desc     : Bit-period counter; bit_end marks the last clk of each serial bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  assign bit_end = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_cfg
// Desc     : Parameterised UART transmitter (data width, parity, stop bits).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int      DATA_W       = 8,
  parameter int      CLKS_PER_BIT = 16,
  parameter parity_e PARITY       = PAR_NONE,
  parameter int      STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  if ((DATA_W < 5) || (DATA_W > 16)) begin : g_bad_data_w
    $error("uart_tx_cfg: DATA_W must be in 5..16");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_cfg: CLKS_PER_BIT must be at least 2");
  end
  if ((PARITY != PAR_NONE) && (PARITY != PAR_EVEN) && (PARITY != PAR_ODD)) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be PAR_NONE, PAR_EVEN or PAR_ODD");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  localparam int c_idx_w = $clog2(DATA_W);
  localparam logic [c_idx_w-1:0] c_data_last = c_idx_w'(DATA_W - 1);
  localparam logic [c_idx_w-1:0] c_stop_last = c_idx_w'(STOP_BITS - 1);
  localparam logic c_par_en = (PARITY != PAR_NONE);

  state_e              r_state;
  logic [DATA_W-1:0]   r_shift;
  logic [c_idx_w-1:0]  r_bit_idx;
  logic                r_par;
  logic                r_tx;

  logic w_handshake;
  logic w_bit_end;
  logic w_baud_clr;

  assign tx_ready    = (r_state == ST_IDLE) && !rst;
  assign w_handshake = tx_valid && tx_ready;
  // Holding the counter clear while idle aligns the first bit to the handshake.
  assign w_baud_clr  = w_handshake || (r_state == ST_IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_baud_clr),
    .bit_end(w_bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_tx      <= 1'b1;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_par     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_handshake) begin
            r_shift   <= tx_data;
            r_par     <= parity_bit(PARITY, ^tx_data);
            r_bit_idx <= '0;
            r_tx      <= 1'b0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == c_data_last) begin
              r_bit_idx <= '0;
              if (c_par_en) begin
                r_tx    <= r_par;
                r_state <= ST_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              r_bit_idx <= r_bit_idx + c_idx_w'(1);
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_tx    <= 1'b1;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) begin
            if (r_bit_idx == c_stop_last) begin
              r_bit_idx <= '0;
              r_state   <= ST_IDLE;
            end else begin
              r_bit_idx <= r_bit_idx + c_idx_w'(1);
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx      = r_tx;
  assign tx_busy = (r_state != ST_IDLE);
  // Marks the last clk of the final stop bit; a reset in that cycle cancels it.
  assign tx_done = !rst && (r_state == ST_STOP) && w_bit_end && (r_bit_idx == c_stop_last);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_cfg
// Desc     : Self-checking bench for uart_tx_cfg across four configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;
  import uart_pkg::*;

  localparam int c_n    = 4;
  localparam int c_cpb  = 4;
  localparam int c_par  [c_n] = '{0, 1, 2, 0};
  localparam int c_stop [c_n] = '{1, 1, 1, 2};

  typedef struct {
    int          inst;
    logic [7:0]  data;
    int          nbits;
    logic [11:0] frame;
    int          len;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v    [c_n];
  logic [7:0] d    [c_n];
  logic       rdy  [c_n];
  logic       txl  [c_n];
  logic       busy [c_n];
  logic       done [c_n];

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] exp_q [c_n][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < c_n; g++) begin : g_dut
    uart_tx_cfg #(
      .DATA_W      (8),
      .CLKS_PER_BIT(c_cpb),
      .PARITY      (parity_e'(c_par[g])),
      .STOP_BITS   (c_stop[g])
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .tx_valid(v[g]),
      .tx_data (d[g]),
      .tx_ready(rdy[g]),
      .tx      (txl[g]),
      .tx_busy (busy[g]),
      .tx_done (done[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input int i);
    int t;
    t = 0;
    while (!rdy[i] && t < 200) begin
      tick;
      t++;
    end
    check($sformatf("hs_wait%0d", i), rdy[i], 1);
  endtask

  // Offer one word, return the cycle tx_done was seen and the mid-bit samples.
  task automatic send(input int i, input logic [7:0] data, input int nbits,
                      output int len, output logic [11:0] frame);
    int c;
    v[i] = 1'b1;
    d[i] = data;
    wait_rdy(i);
    tick;
    v[i]  = 1'b0;
    d[i]  = ~data;
    frame = '0;
    len   = 0;
    c     = 1;
    while (c < 200) begin
      if ((c % c_cpb) == 2 && (c / c_cpb) < nbits) frame[c / c_cpb] = txl[i];
      if (done[i]) begin
        len = c;
        break;
      end
      tick;
      c++;
    end
  endtask

  // Scoreboard: a frame's cycle-by-cycle line image is queued when a handshake
  // is about to happen, then consumed one entry per clk.
  always @(negedge clk) begin : p_mon
    logic [2:0]  e;
    logic        e_rdy;
    logic [15:0] fb;
    int          nb;
    for (int i = 0; i < c_n; i++) begin
      if (exp_q[i].size() != 0) begin
        e     = exp_q[i].pop_front();
        e_rdy = 1'b0;
      end else begin
        e     = 3'b100;
        e_rdy = !rst;
      end
      check($sformatf("line%0d", i), {txl[i], busy[i], done[i], rdy[i]}, {e, e_rdy});
      if (rst) begin
        exp_q[i].delete();
      end else if (v[i] && rdy[i]) begin
        check($sformatf("hs_idle%0d", i), exp_q[i].size(), 0);
        fb      = '0;
        fb[8:1] = d[i];
        nb      = 9;
        if (c_par[i] != 0) begin
          fb[nb] = (^d[i]) ^ (c_par[i] == 2);
          nb++;
        end
        for (int s = 0; s < c_stop[i]; s++) begin
          fb[nb] = 1'b1;
          nb++;
        end
        for (int b = 0; b < nb; b++) begin
          for (int t = 0; t < c_cpb; t++) begin
            exp_q[i].push_back({fb[b], 1'b1, (b == nb - 1) && (t == c_cpb - 1)});
          end
        end
      end
    end
  end

  initial begin : p_main
    vec_t        vecs [8];
    int          len;
    int          c;
    int          seen;
    logic [11:0] fr;

    for (int i = 0; i < c_n; i++) begin
      v[i] = 1'b0;
      d[i] = 8'h00;
    end
    vecs[0] = '{0, 8'hA5, 10, {2'b00, 1'b1, 8'hA5, 1'b0}, 40};
    vecs[1] = '{1, 8'h07, 11, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 44};
    vecs[2] = '{2, 8'h07, 11, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 44};
    vecs[3] = '{3, 8'h00, 11, {1'b0, 2'b11, 8'h00, 1'b0}, 44};
    vecs[4] = '{0, 8'h3C, 10, {2'b00, 1'b1, 8'h3C, 1'b0}, 40};
    vecs[5] = '{1, 8'h5A, 11, {1'b0, 1'b1, 1'b0, 8'h5A, 1'b0}, 44};
    vecs[6] = '{2, 8'hFF, 11, {1'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, 44};
    vecs[7] = '{3, 8'hFF, 11, {1'b0, 2'b11, 8'hFF, 1'b0}, 44};

    repeat (3) tick;
    for (int i = 0; i < c_n; i++) begin
      check($sformatf("rst_rdy%0d", i), rdy[i], 0);
      check($sformatf("rst_tx%0d", i), txl[i], 1);
      check($sformatf("rst_busy%0d", i), busy[i], 0);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < c_n; i++) begin
      check($sformatf("idle_rdy%0d", i), rdy[i], 1);
      check($sformatf("idle_done%0d", i), done[i], 0);
    end
    tick;

    for (int k = 0; k < 8; k++) begin
      send(vecs[k].inst, vecs[k].data, vecs[k].nbits, len, fr);
      check($sformatf("frame%0d", k), fr, vecs[k].frame);
      check($sformatf("len%0d", k), len, vecs[k].len);
      repeat (2) tick;
    end

    // Back-to-back with tx_valid held: 0x3C then 0xC3.
    v[0] = 1'b1;
    d[0] = 8'h3C;
    wait_rdy(0);
    tick;
    d[0] = 8'hC3;
    c = 1;
    while (!done[0] && c < 200) begin
      tick;
      c++;
    end
    check("b2b_done1", c, 40);
    check("b2b_rdy_in_done", rdy[0], 0);
    tick;
    check("b2b_gap_tx", txl[0], 1);
    check("b2b_gap_rdy", rdy[0], 1);
    check("b2b_gap_busy", busy[0], 0);
    tick;
    v[0] = 1'b0;
    check("b2b_start2", txl[0], 0);
    c = 1;
    while (!done[0] && c < 200) begin
      tick;
      c++;
    end
    check("b2b_done2", c, 40);
    repeat (2) tick;

    // Reset pulsed at cycle 10 of a frame.
    v[0] = 1'b1;
    d[0] = 8'h55;
    wait_rdy(0);
    tick;
    v[0] = 1'b0;
    d[0] = 8'hAA;
    repeat (9) tick;
    rst = 1'b1;
    tick;
    check("rst_mid_tx", txl[0], 1);
    check("rst_mid_busy", busy[0], 0);
    check("rst_mid_rdy", rdy[0], 0);
    rst = 1'b0;
    #1;
    check("rst_rel_rdy", rdy[0], 1);
    check("rst_rel_tx", txl[0], 1);
    seen = 0;
    repeat (50) begin
      tick;
      if (done[0]) seen++;
    end
    check("rst_no_done", seen, 0);
    send(0, 8'h81, 10, len, fr);
    check("rst_next_frame", fr, {2'b00, 1'b1, 8'h81, 1'b0});
    check("rst_next_len", len, 40);
    repeat (3) tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
